ad9914_reg_xfer: RTL and testbench

AD9914_REG_XFER -- requirements
Module: ad9914_reg_xfer

---
 rtl/ad9914_reg_xfer.sv | 185 ++++++++++++++++++
 tb/tb_ad9914_reg_xfer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9914_reg_xfer.sv
// rtl/ad9914_reg_xfer.sv - AD9914 multi-word register write with read-back verify, retry and IO_UPDATE pulse
module ad9914_reg_xfer #(
   parameter int WORDS_MAX        = 4,
   parameter int IO_UPDATE_CYCLES = 2,
   parameter int MAX_RETRY        = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [7:0]             base_addr,
   input  logic [16*WORDS_MAX-1:0] wvar,
   input  logic [3:0]             word_num,
   input  logic                   read_back_disable,
   input  logic                   io_update_en,
   output logic [16*WORDS_MAX-1:0] rvar,
   output logic                   busy,
   output logic                   finish,
   output logic [1:0]             err,
   output logic [2:0]             retry_cnt,
   output logic                   io_update,
   output logic                   p_load,
   output logic                   p_wr_cmd,
   output logic [7:0]             p_addr,
   output logic [15:0]            p_wdata,
   input  logic [15:0]            p_rdata,
   input  logic                   p_busy,
   input  logic                   p_finish
);

   localparam int IW = (WORDS_MAX > 1) ? $clog2(WORDS_MAX) : 1;
   localparam int UW = $clog2(IO_UPDATE_CYCLES + 1);

   typedef enum logic [3:0] {
      IDLE, WR_REQ, WR_ACK, RD_REQ, RD_ACK, RD_WAIT, CHECK, UPDATE, DONE
   } state_t;

   state_t         state;
   logic [15:0]    wv [WORDS_MAX];
   logic [15:0]    rv [WORDS_MAX];
   logic [7:0]     base_q;
   logic [3:0]     wn_q;
   logic           rbd_q;
   logic           upd_q;
   logic [IW-1:0]  idx;
   logic [UW-1:0]  upd_cnt;
   logic           last_word;
   logic           mismatch;
   logic [7:0]     cmd_addr;

   assign last_word = ({{(4-IW){1'b0}}, idx} == wn_q - 4'd1);
   // Word i lives at the odd byte address of its 16-bit slot; wraps at 256.
   assign cmd_addr  = 8'({base_q, 2'b00} + 10'({idx, 1'b1}));

   for (genvar g = 0; g < WORDS_MAX; g++) begin : g_rvar
      assign rvar[16*g +: 16] = rv[g];
   end

   always_comb begin
      mismatch = 1'b0;
      for (int k = 0; k < WORDS_MAX; k++) begin
         if ((4'(k) < wn_q) && (rv[k] != wv[k])) mismatch = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         p_load    <= 1'b0;
         p_wr_cmd  <= 1'b0;
         p_addr    <= 8'h00;
         p_wdata   <= 16'h0000;
         busy      <= 1'b0;
         finish    <= 1'b1;
         err       <= 2'b00;
         retry_cnt <= 3'd0;
         io_update <= 1'b0;
         idx       <= '0;
         upd_cnt   <= '0;
         for (int k = 0; k < WORDS_MAX; k++) rv[k] <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  base_q    <= base_addr;
                  wn_q      <= word_num;
                  rbd_q     <= read_back_disable;
                  upd_q     <= io_update_en;
                  for (int k = 0; k < WORDS_MAX; k++) wv[k] <= wvar[16*k +: 16];
                  busy      <= 1'b1;
                  finish    <= 1'b0;
                  retry_cnt <= 3'd0;
                  idx       <= '0;
                  if (word_num == 4'd0 || word_num > 4'(WORDS_MAX)) begin
                     err   <= 2'b10;
                     state <= DONE;
                  end else begin
                     err   <= 2'b00;
                     state <= WR_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (p_finish) begin
                  p_addr   <= cmd_addr;
                  p_wdata  <= wv[idx];
                  p_wr_cmd <= 1'b0;
                  p_load   <= 1'b1;
                  state    <= WR_ACK;
               end
            end
            WR_ACK: begin
               if (p_busy) begin
                  p_load <= 1'b0;
                  if (last_word) begin
                     idx     <= '0;
                     upd_cnt <= '0;
                     state   <= rbd_q ? UPDATE : RD_REQ;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= WR_REQ;
                  end
               end
            end
            RD_REQ: begin
               if (p_finish) begin
                  p_addr   <= cmd_addr;
                  p_wr_cmd <= 1'b1;
                  p_load   <= 1'b1;
                  state    <= RD_ACK;
               end
            end
            RD_ACK: begin
               if (p_busy) begin
                  p_load <= 1'b0;
                  state  <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (p_finish) begin
                  rv[idx] <= p_rdata;
                  if (last_word) begin
                     idx   <= '0;
                     state <= CHECK;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= RD_REQ;
                  end
               end
            end
            CHECK: begin
               if (mismatch) begin
                  if (retry_cnt < 3'(MAX_RETRY)) begin
                     retry_cnt <= retry_cnt + 3'd1;
                     idx       <= '0;
                     state     <= WR_REQ;
                  end else begin
                     err   <= 2'b01;
                     state <= DONE;
                  end
               end else begin
                  err     <= 2'b00;
                  upd_cnt <= '0;
                  state   <= UPDATE;
               end
            end
            UPDATE: begin
               if (upd_q && upd_cnt != UW'(IO_UPDATE_CYCLES)) begin
                  io_update <= 1'b1;
                  upd_cnt   <= upd_cnt + 1'b1;
               end else begin
                  io_update <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE: begin
               busy   <= 1'b0;
               finish <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ad9914_reg_xfer.sv
// tb/tb_ad9914_reg_xfer.sv - scoreboard bench for ad9914_reg_xfer against a parallel_wr responder model
module tb_ad9914_reg_xfer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load = 1'b0;
   logic [7:0]  base_addr = 8'h00;
   logic [63:0] wvar = 64'h0;
   logic [3:0]  word_num = 4'd0;
   logic        read_back_disable = 1'b0;
   logic        io_update_en = 1'b0;
   logic [63:0] rvar;
   logic        busy, finish, io_update;
   logic [1:0]  err;
   logic [2:0]  retry_cnt;
   logic        p_load, p_wr_cmd;
   logic [7:0]  p_addr;
   logic [15:0] p_wdata;
   logic [15:0] p_rdata = 16'h0;
   logic        p_busy = 1'b0;
   logic        p_finish = 1'b1;

   int checks = 0;
   int failures = 0;

   ad9914_reg_xfer #(.WORDS_MAX(4), .IO_UPDATE_CYCLES(2), .MAX_RETRY(2)) dut (
      .clk(clk), .rst(rst), .load(load), .base_addr(base_addr), .wvar(wvar),
      .word_num(word_num), .read_back_disable(read_back_disable), .io_update_en(io_update_en),
      .rvar(rvar), .busy(busy), .finish(finish), .err(err), .retry_cnt(retry_cnt),
      .io_update(io_update), .p_load(p_load), .p_wr_cmd(p_wr_cmd), .p_addr(p_addr),
      .p_wdata(p_wdata), .p_rdata(p_rdata), .p_busy(p_busy), .p_finish(p_finish)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Responder model: accepts a command, stays busy a few cycles, echoes memory on reads
   logic [24:0] exp_q[$];
   logic [24:0] obs_q[$];
   logic [15:0] mem [256];
   int          io_total = 0;
   int          rd_total = 0;
   logic [7:0]  corrupt_addr = 8'h00;
   int          corrupt_before = 0;
   logic        m_busy = 1'b0;
   logic        m_rd = 1'b0;
   logic        m_corrupt = 1'b0;
   logic [7:0]  m_addr = 8'h00;
   int          m_cnt = 0;

   always @(negedge clk) begin
      if (io_update) io_total++;
      if (m_busy) begin
         if (m_cnt == 0) begin
            m_busy = 1'b0;
            if (m_rd) p_rdata = mem[m_addr] ^ (m_corrupt ? 16'h0100 : 16'h0000);
            p_busy   = 1'b0;
            p_finish = 1'b1;
         end else begin
            m_cnt--;
         end
      end else if (p_load) begin
         obs_q.push_back({p_wr_cmd, p_addr, p_wr_cmd ? 16'h0000 : p_wdata});
         if (!p_wr_cmd) mem[p_addr] = p_wdata;
         m_corrupt = p_wr_cmd && (p_addr == corrupt_addr) && (rd_total < corrupt_before);
         if (p_wr_cmd) rd_total++;
         m_rd     = p_wr_cmd;
         m_addr   = p_addr;
         m_cnt    = 2;
         m_busy   = 1'b1;
         p_busy   = 1'b1;
         p_finish = 1'b0;
      end
   end

   function automatic logic [7:0] xaddr(input logic [7:0] b, input int j);
      return 8'({b, 2'b00} + 10'(2 * j + 1));
   endfunction

   task automatic push_pass(input logic [7:0] b, input logic [63:0] wv, input int wn, input logic rbd);
      for (int j = 0; j < wn; j++) exp_q.push_back({1'b0, xaddr(b, j), wv[16*j +: 16]});
      if (!rbd) for (int j = 0; j < wn; j++) exp_q.push_back({1'b1, xaddr(b, j), 16'h0000});
   endtask

   task automatic compare_sb(input string tag);
      chk({tag, "_ncmds"}, 64'(obs_q.size()), 64'(exp_q.size()));
      while (obs_q.size() > 0 && exp_q.size() > 0) chk({tag, "_cmd"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
      obs_q.delete();
      exp_q.delete();
   endtask

   int last_busy;
   int last_io;

   task automatic run_xfer(input logic [7:0] b, input logic [63:0] wv, input logic [3:0] wn,
                           input logic rbd, input logic upd, input int passes);
      int io0;
      int t;
      if (wn != 0 && wn <= 4) for (int p = 0; p < passes; p++) push_pass(b, wv, int'(wn), rbd);
      io0 = io_total;
      base_addr = b; wvar = wv; word_num = wn; read_back_disable = rbd; io_update_en = upd;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      last_busy = 0;
      t = 0;
      while (!(finish && !busy) && t < 5000) begin
         if (busy) last_busy++;
         @(negedge clk);
         t++;
      end
      chk("done_in_time", {63'b0, finish & ~busy}, 64'h1);
      last_io = io_total - io0;
   endtask

   logic [63:0] wv3;
   logic [63:0] wv5;
   int          t;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", {63'b0, busy}, 64'h0);
      chk("rst_finish", {63'b0, finish}, 64'h1);
      chk("rst_err", {62'b0, err}, 64'h0);
      chk("rst_rvar", rvar, 64'h0);
      chk("rst_pload", {63'b0, p_load}, 64'h0);
      rst = 1'b1;
      @(negedge clk);

      // Two words, no read-back, with IO_UPDATE
      run_xfer(8'h03, 64'h0000_0000_1234_5678, 4'd2, 1'b1, 1'b1, 1);
      compare_sb("wr2");
      chk("wr2_io", 64'(last_io), 64'd2);
      chk("wr2_err", {62'b0, err}, 64'h0);
      chk("wr2_retry", {61'b0, retry_cnt}, 64'h0);
      chk("wr2_rvar", rvar, 64'h0);

      // Four words with echo read-back
      wv3 = {$urandom(), $urandom()};
      run_xfer(8'h10, wv3, 4'd4, 1'b0, 1'b1, 1);
      compare_sb("rb4");
      chk("rb4_rvar", rvar, wv3);
      chk("rb4_err", {62'b0, err}, 64'h0);
      chk("rb4_retry", {61'b0, retry_cnt}, 64'h0);
      chk("rb4_io", 64'(last_io), 64'd2);

      // Word 1 corrupted on every read: retries exhausted
      corrupt_addr = xaddr(8'h20, 1);
      corrupt_before = rd_total + 1000;
      run_xfer(8'h20, 64'h0000_0000_BEEF_CAFE, 4'd2, 1'b0, 1'b1, 3);
      corrupt_before = 0;
      compare_sb("bad");
      chk("bad_err", {62'b0, err}, 64'h1);
      chk("bad_retry", {61'b0, retry_cnt}, 64'h2);
      chk("bad_io", 64'(last_io), 64'd0);
      chk("bad_rvar1", {48'b0, rvar[31:16]}, 64'h0000_0000_0000_BFEF);

      // Only the first read pass corrupted; word 3 must survive from the 4-word transfer
      wv5 = {16'hFFFF, 16'h0A0A, 16'h5A5A, 16'hC3C3};
      corrupt_addr = xaddr(8'h30, 1);
      corrupt_before = rd_total + 3;
      run_xfer(8'h30, wv5, 4'd3, 1'b0, 1'b1, 2);
      corrupt_before = 0;
      compare_sb("once");
      chk("once_err", {62'b0, err}, 64'h0);
      chk("once_retry", {61'b0, retry_cnt}, 64'h1);
      chk("once_io", 64'(last_io), 64'd2);
      chk("once_rvar_lo", {16'b0, rvar[47:0]}, {16'b0, wv5[47:0]});
      chk("once_rvar_w3", {48'b0, rvar[63:48]}, {48'b0, wv3[63:48]});

      // Illegal word counts
      run_xfer(8'h40, 64'h1111_2222_3333_4444, 4'd0, 1'b0, 1'b1, 1);
      compare_sb("wn0");
      chk("wn0_err", {62'b0, err}, 64'h2);
      chk("wn0_busy_le2", {63'b0, last_busy <= 2}, 64'h1);
      chk("wn0_io", 64'(last_io), 64'd0);
      run_xfer(8'h40, 64'h1111_2222_3333_4444, 4'd5, 1'b0, 1'b1, 1);
      compare_sb("wn5");
      chk("wn5_err", {62'b0, err}, 64'h2);
      chk("wn5_busy_le2", {63'b0, last_busy <= 2}, 64'h1);

      // Address wrap, IO_UPDATE disabled; err cleared by the new load
      run_xfer(8'hFF, 64'h0000_0000_9999_7777, 4'd2, 1'b1, 1'b0, 1);
      compare_sb("wrap");
      chk("wrap_err", {62'b0, err}, 64'h0);
      chk("wrap_io", 64'(last_io), 64'd0);

      // Reset in RD_WAIT with an ignored load while busy
      push_pass(8'h50, 64'h4444_3333_2222_1111, 4, 1'b1);
      exp_q.push_back({1'b1, xaddr(8'h50, 0), 16'h0000});
      base_addr = 8'h50; wvar = 64'h4444_3333_2222_1111; word_num = 4'd4;
      read_back_disable = 1'b0; io_update_en = 1'b1;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (4) @(negedge clk);
      base_addr = 8'h80; word_num = 4'd1;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      t = 0;
      while (!(p_load && p_wr_cmd) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("rd_seen", {63'b0, p_load & p_wr_cmd}, 64'h1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_pload", {63'b0, p_load}, 64'h0);
      chk("mid_pwr", {63'b0, p_wr_cmd}, 64'h0);
      chk("mid_paddr", {56'b0, p_addr}, 64'h0);
      chk("mid_pwdata", {48'b0, p_wdata}, 64'h0);
      chk("mid_rvar", rvar, 64'h0);
      chk("mid_busy", {63'b0, busy}, 64'h0);
      chk("mid_finish", {63'b0, finish}, 64'h1);
      chk("mid_err", {62'b0, err}, 64'h0);
      chk("mid_retry", {61'b0, retry_cnt}, 64'h0);
      chk("mid_io", {63'b0, io_update}, 64'h0);
      rst = 1'b1;
      compare_sb("mid");
      repeat (20) @(negedge clk);
      compare_sb("post_rst");

      // Reset cuts an active IO_UPDATE pulse
      push_pass(8'h05, 64'h0000_0000_0000_ABCD, 1, 1'b1);
      base_addr = 8'h05; wvar = 64'h0000_0000_0000_ABCD; word_num = 4'd1;
      read_back_disable = 1'b1; io_update_en = 1'b1;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      t = 0;
      while (!io_update && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("cut_seen", {63'b0, io_update}, 64'h1);
      rst = 1'b0;
      @(negedge clk);
      chk("cut_io", {63'b0, io_update}, 64'h0);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      compare_sb("cut");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
